control_unit_legv8: RTL and testbench



---
 rtl/control_unit_legv8.sv | 152 +++++++++++++++
 tb/tb_control_unit_legv8.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit_legv8.sv
// Multi-cycle LEGv8 control sequencer: fetches over a req/valid handshake, owns the PC,
// and drives the datapath control word and constant from the registered state and IR.
module control_unit_legv8 #(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter logic [4:0]  SCRATCH_REG = 5'd16,
    parameter logic [4:0]  FS_AND      = 5'b00000,
    parameter logic [4:0]  FS_ORR      = 5'b00100,
    parameter logic [4:0]  FS_ADD      = 5'b01000,
    parameter logic [4:0]  FS_SUB      = 5'b01001,
    parameter logic [4:0]  FS_PASSA    = 5'b11100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        instr_valid,
    input  logic [3:0]  status,
    output logic [24:0] control_word,
    output logic [63:0] constant,
    output logic [63:0] pc,
    output logic        instr_req,
    output logic        retired,
    output logic        halted,
    output logic        illegal
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_ST2, S_HALTED} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI,
        OP_LDUR, OP_STUR, OP_CBZ, OP_B, OP_HALT, OP_BAD
    } op_t;

    state_t      state, state_next;
    op_t         op;
    logic [31:0] ir;
    logic [63:0] pc_next;
    logic        done;

    logic [4:0]  sa, sb, da, fs;
    logic        reg_write, mem_write, bsel, en_mem, en_alu;
    logic [63:0] const_v;

    // Only Z is consumed; the other flags are carried for completeness.
    logic unused_flags;
    assign unused_flags = &{1'b0, status[3:1]};

    always_comb begin
        op = OP_BAD;
        if (ir == 32'd0)                        op = OP_HALT;
        else if (ir[31:21] == 11'b10001011000)  op = OP_ADD;
        else if (ir[31:21] == 11'b11001011000)  op = OP_SUB;
        else if (ir[31:21] == 11'b10001010000)  op = OP_AND;
        else if (ir[31:21] == 11'b10101010000)  op = OP_ORR;
        else if (ir[31:21] == 11'b11111000010)  op = OP_LDUR;
        else if (ir[31:21] == 11'b11111000000)  op = OP_STUR;
        else if (ir[31:22] == 10'b1001000100)   op = OP_ADDI;
        else if (ir[31:22] == 10'b1101000100)   op = OP_SUBI;
        else if (ir[31:24] == 8'b10110100)      op = OP_CBZ;
        else if (ir[31:26] == 6'b000101)        op = OP_B;
    end

    // Final execute edge of a real instruction: EXEC for all but STUR, ST2 for STUR.
    assign done = (state == S_ST2) ||
                  (state == S_EXEC && op != OP_STUR && op != OP_HALT && op != OP_BAD);

    always_comb begin
        pc_next = pc + 64'd4;
        if (state == S_EXEC && op == OP_B)
            pc_next = pc + {{36{ir[25]}}, ir[25:0], 2'b00};
        else if (state == S_EXEC && op == OP_CBZ && status[0])
            pc_next = pc + {{43{ir[23]}}, ir[23:5], 2'b00};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= 32'd0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_FETCH && instr_valid) ir <= instruction;
            if (done) pc <= pc_next;
            if (state == S_EXEC && (op == OP_HALT || op == OP_BAD)) halted <= 1'b1;
            if (state == S_EXEC && op == OP_BAD) illegal <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (instr_valid) state_next = S_EXEC;
            S_EXEC: begin
                if (op == OP_HALT || op == OP_BAD) state_next = S_HALTED;
                else if (op == OP_STUR)            state_next = S_ST2;
                else                               state_next = S_FETCH;
            end
            S_ST2:    state_next = S_FETCH;
            default:  state_next = S_HALTED;
        endcase
    end

    always_comb begin
        sa = 5'd0; sb = 5'd0; da = 5'd0; fs = 5'd0;
        reg_write = 1'b0; mem_write = 1'b0; bsel = 1'b0; en_mem = 1'b0; en_alu = 1'b0;
        const_v = 64'd0;
        if (state == S_EXEC) begin
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI: begin
                    sa = ir[9:5]; sb = ir[20:16]; da = ir[4:0];
                    reg_write = 1'b1; en_alu = 1'b1;
                    case (op)
                        OP_SUB, OP_SUBI: fs = FS_SUB;
                        OP_AND:          fs = FS_AND;
                        OP_ORR:          fs = FS_ORR;
                        default:         fs = FS_ADD;
                    endcase
                    if (op == OP_ADDI || op == OP_SUBI) begin
                        bsel = 1'b1;
                        const_v = {52'd0, ir[21:10]};
                    end
                end
                OP_LDUR: begin
                    sa = ir[9:5]; da = ir[4:0]; fs = FS_ADD; bsel = 1'b1;
                    const_v = {{55{ir[20]}}, ir[20:12]};
                    reg_write = 1'b1; en_mem = 1'b1;
                end
                OP_STUR: begin
                    // Effective address parked in the scratch register for ST2.
                    sa = ir[9:5]; da = SCRATCH_REG; fs = FS_ADD; bsel = 1'b1;
                    const_v = {{55{ir[20]}}, ir[20:12]};
                    reg_write = 1'b1; en_alu = 1'b1;
                end
                OP_CBZ: begin
                    sa = ir[4:0]; fs = FS_ADD; bsel = 1'b1;
                end
                default: ;
            endcase
        end else if (state == S_ST2) begin
            sa = SCRATCH_REG; sb = ir[4:0]; fs = FS_PASSA; mem_write = 1'b1;
        end
        if (reset) begin
            sa = 5'd0; sb = 5'd0; da = 5'd0; fs = 5'd0;
            reg_write = 1'b0; mem_write = 1'b0; bsel = 1'b0; en_mem = 1'b0; en_alu = 1'b0;
            const_v = 64'd0;
        end
    end

    assign control_word = {sa, sb, da, reg_write, mem_write, fs, bsel, en_mem, en_alu};
    assign constant     = const_v;
    assign instr_req    = (state == S_FETCH);
    assign retired      = done && !reset;
endmodule

// File: tb/tb_control_unit_legv8.sv
// Directed bench for control_unit_legv8: hand-encoded LEGv8 words with hand-computed
// control words, constants and PC progression.
module tb_control_unit_legv8;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [3:0]  status;
    logic [24:0] control_word;
    logic [63:0] constant;
    logic [63:0] pc;
    logic        instr_req, retired, halted, illegal;

    int n_chk = 0;
    int n_fail = 0;

    control_unit_legv8 dut (
        .clock(clock), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .status(status), .control_word(control_word), .constant(constant), .pc(pc),
        .instr_req(instr_req), .retired(retired), .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] cw(input logic [4:0] sa, input logic [4:0] sb,
                                       input logic [4:0] da, input logic rw, input logic mw,
                                       input logic [4:0] fs, input logic bs,
                                       input logic em, input logic ea);
        return {sa, sb, da, rw, mw, fs, bs, em, ea};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; instr_valid = 1'b0; instruction = 32'd0; status = 4'd0;
        tick; tick;
        reset = 1'b0;
    endtask

    // Hold off valid for 'delay' FETCH cycles, then hand over w; returns in the EXEC cycle.
    task automatic issue(input logic [31:0] w, input int delay);
        for (int i = 0; i < delay; i++) begin
            instr_valid = 1'b0;
            chk("fetch_req_wait", {63'd0, instr_req}, 64'd1);
            chk("fetch_idle_wait", {39'd0, control_word}, 64'd0);
            tick;
        end
        instr_valid = 1'b1; instruction = w;
        chk("fetch_req", {63'd0, instr_req}, 64'd1);
        chk("fetch_idle", {39'd0, control_word}, 64'd0);
        tick;
        instr_valid = 1'b0; instruction = 32'hDEAD_BEEF;
    endtask

    localparam logic [31:0] I_ADDI = {10'b1001000100, 12'd5, 5'd31, 5'd1};
    localparam logic [31:0] I_SUB  = {11'b11001011000, 5'd2, 6'd0, 5'd1, 5'd3};
    localparam logic [31:0] I_B    = {6'b000101, 26'h3FF_FFFE};
    localparam logic [31:0] I_STUR = {11'b11111000000, 9'h1F8, 2'b00, 5'd2, 5'd5};
    localparam logic [31:0] I_CBZ  = {8'b10110100, 19'd3, 5'd4};
    localparam logic [31:0] I_LDUR = {11'b11111000010, 9'd16, 2'b00, 5'd3, 5'd7};
    localparam logic [31:0] I_ORR  = {11'b10101010000, 5'd11, 6'd0, 5'd10, 5'd9};

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instruction = 32'd0; status = 4'd0;
        tick;
        chk("rst_word", {39'd0, control_word}, 64'd0);
        chk("rst_const", constant, 64'd0);
        chk("rst_pc", pc, 64'd0);
        chk("rst_flags", {61'd0, retired, halted, illegal}, 64'd0);
        tick;
        reset = 1'b0;

        // ADDI X1,X31,#5, zero-latency fetch
        issue(I_ADDI, 0);
        chk("addi_word", {39'd0, control_word}, {39'd0, cw(5'd31, 5'd0, 5'd1, 1, 0, 5'b01000, 1, 0, 1)});
        chk("addi_const", constant, 64'd5);
        chk("addi_ret", {63'd0, retired}, 64'd1);
        chk("addi_pc_exec", pc, 64'd0);
        tick;
        chk("addi_pc", pc, 64'd4);
        chk("addi_ret_off", {63'd0, retired}, 64'd0);

        // SUB X3,X1,X2, valid three cycles late
        issue(I_SUB, 3);
        chk("sub_word", {39'd0, control_word}, {39'd0, cw(5'd1, 5'd2, 5'd3, 1, 0, 5'b01001, 0, 0, 1)});
        tick;
        chk("sub_pc", pc, 64'd8);

        // B #-2 at pc=8
        issue(I_B, 0);
        chk("b_word", {39'd0, control_word}, 64'd0);
        chk("b_ret", {63'd0, retired}, 64'd1);
        tick;
        chk("b_pc", pc, 64'd0);

        // STUR X5,[X2,#-8]
        issue(I_STUR, 0);
        chk("stur_exec_word", {39'd0, control_word}, {39'd0, cw(5'd2, 5'd0, 5'd16, 1, 0, 5'b01000, 1, 0, 1)});
        chk("stur_exec_const", constant, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("stur_exec_ret", {63'd0, retired}, 64'd0);
        tick;
        chk("stur_st2_word", {39'd0, control_word}, {39'd0, cw(5'd16, 5'd5, 5'd0, 0, 1, 5'b11100, 0, 0, 0)});
        chk("stur_st2_pc", pc, 64'd0);
        chk("stur_st2_ret", {63'd0, retired}, 64'd1);
        tick;
        chk("stur_pc", pc, 64'd4);

        // CBZ X4,#+3 taken, then not taken
        status = 4'b0001;
        issue(I_CBZ, 0);
        chk("cbz_word", {39'd0, control_word}, {39'd0, cw(5'd4, 5'd0, 5'd0, 0, 0, 5'b01000, 1, 0, 0)});
        chk("cbz_const", constant, 64'd0);
        tick;
        chk("cbz_taken_pc", pc, 64'd16);
        status = 4'b1110;
        issue(I_CBZ, 1);
        tick;
        chk("cbz_nt_pc", pc, 64'd20);
        status = 4'd0;

        // LDUR X7,[X3,#16]
        issue(I_LDUR, 0);
        chk("ldur_word", {39'd0, control_word}, {39'd0, cw(5'd3, 5'd0, 5'd7, 1, 0, 5'b01000, 1, 1, 0)});
        chk("ldur_const", constant, 64'd16);
        tick;
        chk("ldur_pc", pc, 64'd24);

        // ORR X9,X10,X11
        issue(I_ORR, 0);
        chk("orr_word", {39'd0, control_word}, {39'd0, cw(5'd10, 5'd11, 5'd9, 1, 0, 5'b00100, 0, 0, 1)});
        tick;
        chk("orr_pc", pc, 64'd28);

        // HALT
        issue(32'd0, 0);
        chk("halt_ret", {63'd0, retired}, 64'd0);
        tick;
        chk("halt_flags", {62'd0, halted, illegal}, 64'd2);
        chk("halt_req", {63'd0, instr_req}, 64'd0);
        chk("halt_word", {39'd0, control_word}, 64'd0);
        chk("halt_pc", pc, 64'd28);
        tick; tick;
        chk("halt_sticky", {62'd0, halted, instr_req}, 64'd2);

        // Illegal opcode
        do_reset;
        chk("post_rst_halted", {63'd0, halted}, 64'd0);
        issue(32'h1234_5678, 0);
        chk("ill_ret", {63'd0, retired}, 64'd0);
        tick;
        chk("ill_flags", {62'd0, halted, illegal}, 64'd3);
        chk("ill_pc", pc, 64'd0);

        // Reset while in ST2
        do_reset;
        issue(I_STUR, 0);
        tick;
        chk("st2_mw_before", {63'd0, control_word[8]}, 64'd1);
        reset = 1'b1;
        #1;
        chk("st2_rst_mw", {63'd0, control_word[8]}, 64'd0);
        chk("st2_rst_ret", {63'd0, retired}, 64'd0);
        tick;
        reset = 1'b0;
        #1;
        chk("st2_rst_pc", pc, 64'd0);
        chk("st2_rst_fetch", {63'd0, instr_req}, 64'd1);
        chk("st2_rst_word", {39'd0, control_word}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
